servo_pwm_frame_gen: RTL



---
 rtl/servo_pwm_frame_gen.sv | 88 ++++++++
 1 files changed

// File: rtl/servo_pwm_frame_gen.sv
// Frame-based servo PWM: clamps the position command to the legal pulse range and slew-limits width changes.
// Commands are sampled only in the last cycle of a frame and take effect in the next frame, so a pulse is never cut or stretched.
module servo_pwm_frame_gen #(
  parameter int unsigned FRAME_CYCLES = 1000000,
  parameter int unsigned MIN_PULSE    = 50000,
  parameter int unsigned MAX_PULSE    = 100000,
  parameter int unsigned STEP         = 2500
) (
  input  logic        clock_clk,
  input  logic        reset_low,
  input  logic [31:0] pos_cmd,
  output logic        pwm_out,
  output logic        frame_start,
  output logic [31:0] active_width,
  output logic        at_target
);

  localparam logic [31:0] C_LAST = 32'(FRAME_CYCLES - 1);
  localparam logic [31:0] C_MIN  = 32'(MIN_PULSE);
  localparam logic [31:0] C_MAX  = 32'(MAX_PULSE);
  localparam logic [31:0] C_STEP = 32'(STEP);

  logic [31:0] r_cnt;
  logic [31:0] r_width;
  logic        r_pwm;
  logic        r_frame_start;
  logic        r_at_target;

  logic        w_last;
  logic [31:0] w_cnt_nxt;
  logic [31:0] w_tgt;
  logic [31:0] w_width_nxt;

  assign w_last    = (r_cnt == C_LAST);
  assign w_cnt_nxt = w_last ? 32'd0 : r_cnt + 32'd1;

  always_comb begin
    w_tgt = pos_cmd;
    if (pos_cmd != 32'd0 && pos_cmd < C_MIN) begin
      w_tgt = C_MIN;
    end else if (pos_cmd > C_MAX) begin
      w_tgt = C_MAX;
    end
  end

  // Disable and first enable bypass the slew limit; otherwise step toward the target without overshoot.
  always_comb begin
    w_width_nxt = w_tgt;
    if (pos_cmd == 32'd0) begin
      w_width_nxt = 32'd0;
    end else if (r_width == 32'd0 || C_STEP == 32'd0) begin
      w_width_nxt = w_tgt;
    end else if (w_tgt > r_width) begin
      if ((w_tgt - r_width) > C_STEP) begin
        w_width_nxt = r_width + C_STEP;
      end
    end else if ((r_width - w_tgt) > C_STEP) begin
      w_width_nxt = r_width - C_STEP;
    end
  end

  // Outputs are computed from the next count so pwm_out is a plain flop aligned with the count it reflects.
  always_ff @(posedge clock_clk or negedge reset_low) begin
    if (!reset_low) begin
      r_cnt         <= 32'd0;
      r_width       <= 32'd0;
      r_pwm         <= 1'b0;
      r_frame_start <= 1'b0;
      r_at_target   <= 1'b0;
    end else begin
      r_cnt         <= w_cnt_nxt;
      r_frame_start <= w_last;
      if (w_last) begin
        r_width     <= w_width_nxt;
        r_at_target <= (w_width_nxt == w_tgt);
        r_pwm       <= (w_width_nxt != 32'd0);
      end else begin
        r_pwm       <= (w_cnt_nxt < r_width);
      end
    end
  end

  assign pwm_out      = r_pwm;
  assign frame_start  = r_frame_start;
  assign active_width = r_width;
  assign at_target    = r_at_target;

endmodule
